// File: rtl/up_uart.sv
// Byte-wide UART (8N1, LSB first, idle high) feeding the processor memory's serial-load port.
// Define UP_UART_PARITY_EN to switch the frame to 8E1 (even parity between d7 and stop).
module up_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_data,
  output logic       busy_tx,
  output logic [7:0] rx_data,
  output logic       recived,
  output logic       frame_err,
  output logic [2:0] rx_state_dbg,
  output logic [2:0] tx_state_dbg
);

  // Handshake: transmit is a one-cycle request honoured only while busy_tx is low and
  // busy_tx did not fall in that same cycle; recived/frame_err are one-cycle strobes, never together.

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    R_IDLE      = 3'd0,
    R_START     = 3'd1,
    R_DATA      = 3'd2,
    R_STOP      = 3'd3,
    R_WAIT_HIGH = 3'd4
`ifdef UP_UART_PARITY_EN
    , R_PARITY  = 3'd5
`endif
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_START  = 3'd1,
    T_DATA   = 3'd2,
    T_STOP   = 3'd3
`ifdef UP_UART_PARITY_EN
    , T_PARITY = 3'd4
`endif
  } tx_state_e;

  // ---------------------------------------------------------------- rx synchroniser
  logic rx_meta_q, rxs_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- receive FSM
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             recived_q, recived_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_bit_done;
  logic             stop_ok;

`ifdef UP_UART_PARITY_EN
  logic rx_perr_q, rx_perr_d;
  assign stop_ok = rxs_q && !rx_perr_q;
`else
  assign stop_ok = rxs_q;
`endif

  assign rx_bit_done = (rx_cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      recived_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UP_UART_PARITY_EN
      rx_perr_q   <= 1'b0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      recived_q   <= recived_d;
      frame_err_q <= frame_err_d;
`ifdef UP_UART_PARITY_EN
      rx_perr_q   <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_ONE;
    rx_idx_d    = rx_idx_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    recived_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UP_UART_PARITY_EN
    rx_perr_d   = rx_perr_q;
`endif
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs_q) rx_state_d = R_START;
      end
      R_START: begin
        // Half a bit in: a line that is already high again was only a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxs_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_bit_done) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) begin
`ifdef UP_UART_PARITY_EN
            rx_state_d = R_PARITY;
`else
            rx_state_d = R_STOP;
`endif
          end
        end
      end
`ifdef UP_UART_PARITY_EN
      R_PARITY: begin
        if (rx_bit_done) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rxs_q ^ (^rx_sh_q);
          rx_state_d = R_STOP;
        end
      end
`endif
      R_STOP: begin
        if (rx_bit_done) begin
          rx_cnt_d = '0;
          if (stop_ok) begin
            rx_data_d  = rx_sh_q;
            recived_d  = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = rxs_q ? R_IDLE : R_WAIT_HIGH;
          end
        end
      end
      R_WAIT_HIGH: begin
        // A stuck-low line must not be mistaken for a new start bit.
        rx_cnt_d = '0;
        if (rxs_q) rx_state_d = R_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- transmit FSM
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             hold_q, hold_d;
  logic             tx_bit_done;

`ifdef UP_UART_PARITY_EN
  logic tx_par_q, tx_par_d;
`endif

  assign tx_bit_done = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      hold_q     <= 1'b0;
`ifdef UP_UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
`ifdef UP_UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    hold_d     = 1'b0;
`ifdef UP_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        // hold_q blanks the cycle in which busy_tx has just fallen.
        if (transmit && !hold_q) begin
          tx_sh_d    = tx_data;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          tx_state_d = T_START;
`ifdef UP_UART_PARITY_EN
          tx_par_d   = ^tx_data;
`endif
        end
      end
      T_START: begin
        if (tx_bit_done) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_bit_done) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
`ifdef UP_UART_PARITY_EN
            tx_d       = tx_par_q;
            tx_state_d = T_PARITY;
`else
            tx_d       = 1'b1;
            tx_state_d = T_STOP;
`endif
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end
      end
`ifdef UP_UART_PARITY_EN
      T_PARITY: begin
        if (tx_bit_done) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = T_STOP;
        end
      end
`endif
      T_STOP: begin
        if (tx_bit_done) begin
          tx_cnt_d   = '0;
          busy_d     = 1'b0;
          hold_d     = 1'b1;
          tx_state_d = T_IDLE;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  assign tx           = tx_q;
  assign busy_tx      = busy_q;
  assign rx_data      = rx_data_q;
  assign recived      = recived_q;
  assign frame_err    = frame_err_q;
  assign rx_state_dbg = rx_state_q;
  assign tx_state_dbg = tx_state_q;

endmodule

// File: tb/tb_up_uart.sv
// Directed bench for up_uart at 16 clocks per bit; also covers the UP_UART_PARITY_EN build.
module tb_up_uart;

  localparam int CPB = 16;
`ifdef UP_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam logic [2:0] RS_IDLE  = 3'd0;
  localparam logic [2:0] RS_START = 3'd1;
  localparam logic [2:0] RS_WAIT  = 3'd4;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, busy_tx, recived, frame_err;
  logic [7:0] rx_data;
  logic [2:0] rx_state_dbg, tx_state_dbg;

  up_uart #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .nRst(nRst), .rx(rx), .tx(tx), .transmit(transmit), .tx_data(tx_data),
    .busy_tx(busy_tx), .rx_data(rx_data), .recived(recived), .frame_err(frame_err),
    .rx_state_dbg(rx_state_dbg), .tx_state_dbg(tx_state_dbg)
  );

  // ---------------------------------------------------------------- clock / monitors
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         rcv_cnt = 0, fe_cnt = 0, both_cnt = 0, last_rcv_cyc = 0;
  logic [7:0] rcv_byte = 8'h00;
  always @(negedge clk) begin
    if (nRst) begin
      if (recived) begin
        rcv_cnt++;
        last_rcv_cyc = cyc;
        rcv_byte = rx_data;
      end
      if (frame_err) fe_cnt++;
      if (recived && frame_err) both_cnt++;
    end
  end

  int checks = 0, passed = 0;

  // ---------------------------------------------------------------- drivers
  // Frame bits LSB first: start, d0..d7, [parity,] stop; unused top bit is idle-high.
  function automatic logic [10:0] rx_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UP_UART_PARITY_EN
    return {stop, par, d, 1'b0};
`else
    return {par | 1'b1, stop, d, 1'b0};
`endif
  endfunction

  task automatic send_rx(input logic [10:0] bits);
    for (int b = 0; b < NB; b++) begin
      rx = bits[b];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Sends one byte and samples tx mid-bit; poke_at re-pulses transmit at that sample index.
  task automatic run_tx(input logic [7:0] d, input int poke_at, output logic [10:0] seen,
                        output int unstable, output int busy_len);
    logic cur;
    seen = 11'h7FF;
    unstable = 0;
    busy_len = 0;
    cur = 1'b1;
    @(negedge clk); transmit = 1'b1; tx_data = d;
    @(negedge clk); transmit = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < NB * CPB + 10; i++) begin
      if (busy_tx) busy_len++;
      if (i < NB * CPB) begin
        if (i % CPB == 0) cur = tx;
        else if (tx !== cur) unstable++;
        if (i % CPB == CPB / 2) seen[i / CPB] = tx;
      end else if (tx !== 1'b1) unstable++;
      transmit = (i == poke_at);
      if (i == poke_at) tx_data = 8'hFF;
      @(negedge clk);
    end
    transmit = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    int bad;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
    checks++; if (busy_tx !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_tx); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    checks++; if ({recived, frame_err} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {recived, frame_err}); else passed++;
    nRst = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_tx !== 1'b0 || rx_data !== 8'h00 || recived !== 1'b0 || frame_err !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL reset_idle_500: got %0d bad cycles want 0", bad); else passed++;
  endtask

  task automatic test_tx_a5();
    logic [10:0] seen;
    int unstable, busy_len;
    run_tx(8'hA5, -1, seen, unstable, busy_len);
`ifdef UP_UART_PARITY_EN
    checks++; if (seen !== 11'b1_0_10100101_0) $display("FAIL tx_a5_bits: got %b want %b", seen, 11'b1_0_10100101_0); else passed++;
`else
    checks++; if (seen !== 11'b1_1_10100101_0) $display("FAIL tx_a5_bits: got %b want %b", seen, 11'b1_1_10100101_0); else passed++;
`endif
    checks++; if (unstable !== 0) $display("FAIL tx_a5_hold: got %0d glitches want 0", unstable); else passed++;
    checks++; if (busy_len !== NB * CPB) $display("FAIL tx_a5_busy_len: got %0d want %0d", busy_len, NB * CPB); else passed++;
  endtask

  task automatic test_tx_ignore();
    logic [10:0] seen;
    int unstable, busy_len;
    // Second request mid-frame must not disturb the byte already on the line.
    run_tx(8'h3C, 40, seen, unstable, busy_len);
`ifdef UP_UART_PARITY_EN
    checks++; if (seen !== 11'b1_0_00111100_0) $display("FAIL tx_ignore_bits: got %b want %b", seen, 11'b1_0_00111100_0); else passed++;
`else
    checks++; if (seen !== 11'b1_1_00111100_0) $display("FAIL tx_ignore_bits: got %b want %b", seen, 11'b1_1_00111100_0); else passed++;
`endif
    checks++; if (unstable !== 0) $display("FAIL tx_ignore_hold: got %0d glitches want 0", unstable); else passed++;
    checks++; if (busy_len !== NB * CPB) $display("FAIL tx_ignore_busy_len: got %0d want %0d", busy_len, NB * CPB); else passed++;
    // Request in the very cycle busy_tx falls is dropped.
    run_tx(8'h81, NB * CPB, seen, unstable, busy_len);
    checks++; if (busy_len !== NB * CPB) $display("FAIL tx_fall_edge_busy: got %0d want %0d", busy_len, NB * CPB); else passed++;
    checks++; if (unstable !== 0) $display("FAIL tx_fall_edge_line: got %0d glitches want 0", unstable); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk); transmit = 1'b1; tx_data = 8'h0F;
    @(negedge clk); transmit = 1'b0;
    checks++; if ({busy_tx, tx} !== 2'b10) $display("FAIL b2b_first_start: got %b want 10", {busy_tx, tx}); else passed++;
    n = 0;
    while (busy_tx === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (n !== NB * CPB) $display("FAIL b2b_busy_cycles: got %0d want %0d", n, NB * CPB); else passed++;
    @(negedge clk); transmit = 1'b1; tx_data = 8'hF0;
    @(negedge clk); transmit = 1'b0;
    checks++; if ({busy_tx, tx} !== 2'b10) $display("FAIL b2b_accept_after_fall: got %b want 10", {busy_tx, tx}); else passed++;
    n = 0;
    while (busy_tx === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (n !== NB * CPB) $display("FAIL b2b_second_busy: got %0d want %0d", n, NB * CPB); else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx_good(input logic [7:0] d, input string name);
    int r0, f0, start, lat;
    r0 = rcv_cnt; f0 = fe_cnt;
    @(negedge clk);
    start = cyc;
    send_rx(rx_frame(d, 1'b1, ^d));
    rx = 1'b1;
    repeat (20) @(negedge clk);
    lat = last_rcv_cyc - start;
    checks++; if (rcv_cnt - r0 !== 1) $display("FAIL %s_recived_pulses: got %0d want 1", name, rcv_cnt - r0); else passed++;
    checks++; if (rcv_byte !== d) $display("FAIL %s_data: got %h want %h", name, rcv_byte, d); else passed++;
    checks++; if (fe_cnt - f0 !== 0) $display("FAIL %s_frame_err: got %0d want 0", name, fe_cnt - f0); else passed++;
    checks++;
    if (lat < (NB - 1) * CPB + CPB / 2 || lat > (NB - 1) * CPB + CPB / 2 + 10)
      $display("FAIL %s_latency: got %0d want %0d..%0d", name, lat, (NB - 1) * CPB + CPB / 2, (NB - 1) * CPB + CPB / 2 + 10);
    else passed++;
  endtask

  task automatic test_rx_frame_err();
    int r0, f0;
    r0 = rcv_cnt; f0 = fe_cnt;
    @(negedge clk);
    send_rx(rx_frame(8'h55, 1'b0, 1'b0));
    rx = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (fe_cnt - f0 !== 1) $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); else passed++;
    checks++; if (rcv_cnt - r0 !== 0) $display("FAIL ferr_recived: got %0d want 0", rcv_cnt - r0); else passed++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL ferr_rx_data_kept: got %h want 3c", rx_data); else passed++;
    checks++; if (rx_state_dbg !== RS_WAIT) $display("FAIL ferr_stuck_low_state: got %0d want %0d", rx_state_dbg, RS_WAIT); else passed++;
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    checks++; if (rx_state_dbg !== RS_IDLE) $display("FAIL ferr_release_state: got %0d want %0d", rx_state_dbg, RS_IDLE); else passed++;
    test_rx_good(8'h12, "rx_12");
  endtask

  task automatic test_rx_glitch();
    int r0, f0;
    r0 = rcv_cnt; f0 = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    checks++; if (rx_state_dbg !== RS_START) $display("FAIL glitch_seen_start: got %0d want %0d", rx_state_dbg, RS_START); else passed++;
    repeat (40) @(negedge clk);
    checks++; if (rcv_cnt - r0 !== 0) $display("FAIL glitch_recived: got %0d want 0", rcv_cnt - r0); else passed++;
    checks++; if (fe_cnt - f0 !== 0) $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - f0); else passed++;
    checks++; if (rx_state_dbg !== RS_IDLE) $display("FAIL glitch_state: got %0d want %0d", rx_state_dbg, RS_IDLE); else passed++;
  endtask

`ifdef UP_UART_PARITY_EN
  task automatic test_parity();
    int r0, f0, unstable, busy_len;
    logic [10:0] seen;
    r0 = rcv_cnt; f0 = fe_cnt;
    @(negedge clk);
    send_rx(rx_frame(8'h07, 1'b1, 1'b0));
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (fe_cnt - f0 !== 1) $display("FAIL par_rx_frame_err: got %0d want 1", fe_cnt - f0); else passed++;
    checks++; if (rcv_cnt - r0 !== 0) $display("FAIL par_rx_recived: got %0d want 0", rcv_cnt - r0); else passed++;
    checks++; if (rx_state_dbg !== RS_IDLE) $display("FAIL par_rx_state: got %0d want %0d", rx_state_dbg, RS_IDLE); else passed++;
    run_tx(8'h07, -1, seen, unstable, busy_len);
    checks++; if (seen !== 11'b1_1_00000111_0) $display("FAIL par_tx_bits: got %b want %b", seen, 11'b1_1_00000111_0); else passed++;
    checks++; if (busy_len !== 176) $display("FAIL par_tx_busy_len: got %0d want 176", busy_len); else passed++;
  endtask
`endif

  task automatic test_reset_mid_frame();
    @(negedge clk); transmit = 1'b1; tx_data = 8'h00;
    @(negedge clk); transmit = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if ({busy_tx, tx} !== 2'b10) $display("FAIL midrst_in_frame: got %b want 10", {busy_tx, tx}); else passed++;
    nRst = 1'b0;
    #1;
    checks++; if ({busy_tx, tx} !== 2'b01) $display("FAIL midrst_async: got %b want 01", {busy_tx, tx}); else passed++;
    checks++; if (tx_state_dbg !== 3'd0) $display("FAIL midrst_tx_state: got %0d want 0", tx_state_dbg); else passed++;
    @(negedge clk);
    nRst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- sequence / report
  initial begin
    test_reset();
    test_tx_a5();
    test_tx_ignore();
    test_back_to_back();
    test_rx_good(8'h3C, "rx_3c");
    test_rx_frame_err();
    test_rx_glitch();
`ifdef UP_UART_PARITY_EN
    test_parity();
`endif
    checks++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt); else passed++;
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/up_uart.md
Name: up_uart

Overview:
- Byte-wide UART transceiver that sits directly upstream of the processor memory's serial-load port.
- Receive path deserialises the rx line and hands each byte over as rx_data plus a one-cycle recived strobe.
- Transmit path serialises tx_data when transmit is pulsed, and reports busy_tx so the memory knows when the echoed byte has left.
- Fixed frame: 8N1 (8 data bits, no parity, 1 stop bit), LSB first, line idles high.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-period counters; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock
- nRst  input  1  asynchronous reset, active-low
- rx  input  1  serial receive line, asynchronous to clk
- tx  output  1  serial transmit line
- transmit  input  1  single-cycle request to send tx_data
- tx_data  input  8  byte to send, sampled in the cycle transmit is high
- busy_tx  output  1  high while a frame is being sent
- rx_data  output  8  last correctly received byte
- recived  output  1  one-cycle strobe: rx_data has just been updated
- frame_err  output  1  one-cycle strobe: received frame rejected

Behaviour:
- Reset values: tx=1, busy_tx=0, rx_data=8'h00, recived=0, frame_err=0. Both FSMs go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately; tx returns high asynchronously.
- rx passes through a 2-flop synchroniser (resets to 1). All RX decisions use the synchronised value rxs.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH.
  - R_IDLE: on rxs=0, clear the counter and go to R_START.
  - R_START: after CLKS_PER_BIT/2 cycles (integer divide), sample rxs. If 0, go to R_DATA. If 1, treat it as a glitch and return to R_IDLE with no strobe.
  - R_DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift the sample into bit 7 of the shift register, right shift, so the first bit received lands at bit 0. After 8 samples, go to R_STOP.
  - R_STOP: sample after CLKS_PER_BIT cycles. If 1: rx_data <= shift register, recived=1 for exactly the next cycle, go to R_IDLE. If 0: frame_err=1 for one cycle, rx_data unchanged, go to R_WAIT_HIGH.
  - R_WAIT_HIGH: stay until rxs=1, then go to R_IDLE. A stuck-low line must not retrigger.
- recived and frame_err are never high in the same cycle.
- TX FSM states: T_IDLE, T_START, T_DATA, T_STOP.
  - T_IDLE: transmit=1 latches tx_data. From the next cycle, tx=0 and busy_tx=1.
  - Each bit is held for exactly CLKS_PER_BIT cycles: start (0), d0..d7, stop (1).
  - busy_tx falls in the cycle after the stop bit's last cycle, so it stays high for exactly 10*CLKS_PER_BIT cycles.
  - transmit while busy_tx=1 is ignored; no queueing.
  - transmit in the same cycle busy_tx falls is ignored. It is accepted from the following cycle.
- RX and TX are fully independent and may run simultaneously.

Optional Feature:
- Macro: UP_UART_PARITY_EN.
- When defined, the frame becomes 8E1: an even-parity bit (XOR of d0..d7) is inserted between d7 and stop.
  - TX: busy_tx lasts 11*CLKS_PER_BIT cycles.
  - RX: adds state R_PARITY. A parity mismatch gives frame_err=1 and no recived, then the FSM goes to R_WAIT_HIGH if the line is low, otherwise R_IDLE, once the stop bit is sampled.
- When undefined: 8N1 exactly as above; no parity logic is present.

Test Plan:
- Reset, CLKS_PER_BIT=16: tx=1, busy_tx=0, rx_data=00, recived=0, frame_err=0, held with no activity for 500 cycles.
- transmit pulse with tx_data=8'hA5: tx is low for 16 cycles starting the next cycle, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. busy_tx is high for exactly 160 cycles.
- Drive rx with 8'h3C frame at 16 cycles/bit: rx_data=3C and recived is high for exactly one cycle, within 2+8 cycles of the stop-bit midpoint. frame_err stays 0.
- Drive rx with 8'h55 but stop bit 0, holding rx low for 100 cycles afterwards: frame_err pulses once, rx_data keeps its prior value, and no new start is detected until rx returns high. A following 8'h12 frame is then received correctly.
- 4-cycle low glitch on rx: no recived, no frame_err, FSM back in R_IDLE. A second transmit mid-frame (tx_data=8'hFF) is ignored; only the original byte is sent.
- With UP_UART_PARITY_EN, send 8'h07 with parity=0 (wrong): frame_err=1, recived=0. transmit 8'h07: parity bit sent as 1, busy_tx high for 176 cycles.
